axi_w_grant_tracker: RTL and testbench
======================================

# axi_w_grant_tracker

Write-data steering controller placed behind the AW arbitration tree of each slave port in the AXI node. On every AW transfer it records which master won, in an in-order FIFO. It then routes that master's W channel to the slave, one burst at a time, and pops the entry on WLAST. It back-pressures the AW tree when its FIFO is full.

## Interface
Parameters:
- N_MASTER, 5, number of requesting masters
- LOG_MASTER, $clog2(N_MASTER), width of a master index
- FIFO_DEPTH, 4, outstanding AW grants tracked; power of 2, ≥2
- W_WIDTH, 64, flattened W payload width (data+strb+user)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- aw_req_i  in  1  request at the AW tree output
- aw_gnt_i  in  1  grant from the slave side
- aw_gnt_o  out  1  grant forwarded into the tree; equals aw_gnt_i & ~full
- aw_master_gnt_i  in  N_MASTER  per-master grant vector out of the tree; one-hot when aw_gnt_o=1
- w_valid_i  in  N_MASTER  per-master W valid
- w_data_i  in  N_MASTER×W_WIDTH  per-master W payload
- w_last_i  in  N_MASTER  per-master WLAST
- w_ready_o  out  N_MASTER  per-master W ready
- w_valid_o  out  1  W valid to the slave
- w_data_o  out  W_WIDTH  W payload to the slave
- w_last_o  out  1  WLAST to the slave
- w_ready_i  in  1  W ready from the slave
- outstanding_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- beat_cnt_o  out  8  beats already transferred in the current burst; saturates at 255
- onehot_err_o  out  1  sticky; set when a push sees a non-one-hot aw_master_gnt_i

## Operation
- Push condition: aw_req_i & aw_gnt_o. The pushed value is the binary encoding of aw_master_gnt_i, lowest set bit wins.
  - If the vector is zero or has more than one bit set, the entry is still pushed and onehot_err_o is set. onehot_err_o clears only on reset.
- full = (occupancy == FIFO_DEPTH). While full, aw_gnt_o is 0 even if a pop occurs in the same cycle. There is no same-cycle pass-through on a full FIFO.
- Routing is active when the FIFO is non-empty. With head index h:
  - w_valid_o = w_valid_i[h]
  - w_data_o = w_data_i[h]
  - w_last_o = w_last_i[h]
  - w_ready_o[h] = w_ready_i; all other w_ready_o bits are 0
- When the FIFO is empty: w_valid_o=0, w_last_o=0, w_ready_o=0, and w_data_o=0.
- Beat handshake: w_valid_o & w_ready_i.
  - On a beat with w_last_o=1: pop the FIFO and clear beat_cnt_o to 0.
  - On a beat without last: beat_cnt_o increments, saturating at 255.
- Occupancy arithmetic: a simultaneous push and pop (non-full) leaves occupancy unchanged. Pointers are LOG2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Order is strict: bursts are routed in AW grant order. There is no reordering across masters.

## Timing
- Reset (async assert, sync-released by the caller) produces:
  - FIFO empty, pointers 0, outstanding_o=0, beat_cnt_o=0, onehot_err_o=0
  - aw_gnt_o = aw_gnt_i (FIFO not full)
  - all W outputs 0
- Reset mid-burst discards all entries and the partial burst. The next W beat is not routed until a new AW push.
- AW→W latency is 1 cycle: an entry pushed at edge N routes W from cycle N+1. W beats presented in the push cycle itself are not accepted.
- The W path is combinational, with zero added cycles: w_ready_o[h] follows w_ready_i in the same cycle.
- After a pop at edge N, the next head routes from cycle N+1. Back-to-back bursts run with no bubble when occupancy ≥2.
- The AW path is combinational: aw_gnt_o depends only on aw_gnt_i and the registered full flag.
- outstanding_o, beat_cnt_o and onehot_err_o are registered and update on the edge after the event.

## Test plan
- Single burst: push master 2 (aw_master_gnt_i=5'b00100), master 2 sends 4 beats with last on the 4th and w_ready_i=1.
  - Required: w_ready_o=5'b00100 from the cycle after the push.
  - Required: beat_cnt_o counts 0,1,2,3, then returns to 0; outstanding_o goes 1→0 after the last beat.
- In-order steering: push masters 3, 0, 4 on consecutive cycles, and all masters hold valid.
  - Required: slave sees master 3's burst, then master 0's, then master 4's, with no idle cycle between them.
- Full back-pressure: with FIFO_DEPTH=4, push 4 entries while w_ready_i=0.
  - Required: aw_gnt_o=0 while aw_gnt_i=1.
  - After one last-beat handshake, aw_gnt_o=1 on the following cycle; outstanding_o reads 4→3.
- Simultaneous push and pop at occupancy 2: outstanding_o stays 2, and the head advances to the next entry.
- One-hot violation: push with aw_master_gnt_i=5'b00110.
  - Required: head index=1 and onehot_err_o=1 on the next cycle; it stays 1 through later valid pushes until rst_n=0.
- Reset mid-burst: assert rst_n=0 after 2 of 4 beats.
  - Required: all outputs take their reset values immediately (asynchronously).
  - After release, w_valid_i from the old master is not forwarded; w_ready_o=0 until a new push.

Source files
------------

// File: rtl/axi_w_grant_tracker.sv
// W-channel steering behind an AW arbitration tree: records AW winners in an
// in-order FIFO and routes the head master's W burst to the slave until WLAST.
module axi_w_grant_tracker #(
   parameter int N_MASTER   = 5,
   parameter int LOG_MASTER = $clog2(N_MASTER),
   parameter int FIFO_DEPTH = 4,
   parameter int W_WIDTH    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          aw_req_i,
   input  logic                          aw_gnt_i,
   output logic                          aw_gnt_o,
   input  logic [N_MASTER-1:0]           aw_master_gnt_i,
   input  logic [N_MASTER-1:0]           w_valid_i,
   input  logic [N_MASTER*W_WIDTH-1:0]   w_data_i,
   input  logic [N_MASTER-1:0]           w_last_i,
   output logic [N_MASTER-1:0]           w_ready_o,
   output logic                          w_valid_o,
   output logic [W_WIDTH-1:0]            w_data_o,
   output logic                          w_last_o,
   input  logic                          w_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   outstanding_o,
   output logic [7:0]                    beat_cnt_o,
   output logic                          onehot_err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [LOG_MASTER-1:0] fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [7:0]            beat_cnt_q;
   logic                  onehot_err_q;

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  beat;
   logic                  pop;
   logic                  found;
   logic [LOG_MASTER-1:0] push_idx;
   logic [LOG_MASTER-1:0] head;

   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign aw_gnt_o = aw_gnt_i & ~full;
   assign push     = aw_req_i & aw_gnt_o;
   assign head     = fifo_q[rd_ptr_q];

   // Lowest set bit wins; a zero vector encodes as master 0.
   always_comb begin
      push_idx = '0;
      found    = 1'b0;
      for (int m = 0; m < N_MASTER; m++) begin
         if (aw_master_gnt_i[m] && !found) begin
            push_idx = LOG_MASTER'(m);
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      w_valid_o = 1'b0;
      w_last_o  = 1'b0;
      w_data_o  = '0;
      w_ready_o = '0;
      if (!empty) begin
         for (int m = 0; m < N_MASTER; m++) begin
            if (head == LOG_MASTER'(m)) begin
               w_valid_o    = w_valid_i[m];
               w_last_o     = w_last_i[m];
               w_data_o     = w_data_i[m*W_WIDTH +: W_WIDTH];
               w_ready_o[m] = w_ready_i;
            end
         end
      end
   end

   assign beat = w_valid_o & w_ready_i;
   assign pop  = beat & w_last_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         beat_cnt_q   <= '0;
         onehot_err_q <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= push_idx;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            if (!$onehot(aw_master_gnt_i)) begin
               onehot_err_q <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (pop) begin
            beat_cnt_q <= '0;
         end else if (beat && beat_cnt_q != 8'hff) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
         end
      end
   end

   assign outstanding_o = count_q;
   assign beat_cnt_o    = beat_cnt_q;
   assign onehot_err_o  = onehot_err_q;

endmodule

// File: tb/tb_axi_w_grant_tracker.sv
// Randomized bench for axi_w_grant_tracker: queue-based reference model plus a
// beat scoreboard filled at AW-push time and drained on slave-side handshakes.
module tb_axi_w_grant_tracker;

   localparam int NM = 5;
   localparam int LM = 3;
   localparam int D  = 4;
   localparam int WW = 64;

   logic             clk;
   logic             rst_n;
   logic             aw_req_i;
   logic             aw_gnt_i;
   logic             aw_gnt_o;
   logic [NM-1:0]    aw_master_gnt_i;
   logic [NM-1:0]    w_valid_i;
   logic [NM*WW-1:0] w_data_i;
   logic [NM-1:0]    w_last_i;
   logic [NM-1:0]    w_ready_o;
   logic             w_valid_o;
   logic [WW-1:0]    w_data_o;
   logic             w_last_o;
   logic             w_ready_i;
   logic [2:0]       outstanding_o;
   logic [7:0]       beat_cnt_o;
   logic             onehot_err_o;

   axi_w_grant_tracker #(
      .N_MASTER(NM), .LOG_MASTER(LM), .FIFO_DEPTH(D), .W_WIDTH(WW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_req_i(aw_req_i), .aw_gnt_i(aw_gnt_i), .aw_gnt_o(aw_gnt_o),
      .aw_master_gnt_i(aw_master_gnt_i),
      .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_last_i(w_last_i),
      .w_ready_o(w_ready_o), .w_valid_o(w_valid_o), .w_data_o(w_data_o),
      .w_last_o(w_last_o), .w_ready_i(w_ready_i),
      .outstanding_o(outstanding_o), .beat_cnt_o(beat_cnt_o),
      .onehot_err_o(onehot_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // reference model state
   int            grant_q[$];
   int            occ;
   int            mbeat;
   bit            merr;
   logic [64:0]   exp_q[$];
   int            m_len[NM][$];
   int            m_beat[NM];
   int            m_bid[NM];
   int            m_next_bid[NM];
   logic [NM-1:0] fire_s;

   // stimulus knobs
   int            req_pct, gnt_pct, rdy_pct, val_pct;
   logic [NM-1:0] dir_vec;
   int            force_len;
   logic [NM-1:0] stale;

   function automatic logic [63:0] mk(input int m, input int bid, input int b);
      return {8'(m), 8'h5a, 16'(bid), 16'(b), 16'(m * 4099 + bid * 31 + b)};
   endfunction

   always @(negedge clk) begin : model
      int            h;
      bit            ne;
      bit            push, bt, pop;
      int            pm, len;
      logic [NM-1:0] er;
      if (!rst_n) begin
         grant_q.delete();
         exp_q.delete();
         occ   = 0;
         mbeat = 0;
         merr  = 0;
         fire_s = '0;
         for (int m = 0; m < NM; m++) begin
            m_len[m].delete();
            m_beat[m] = 0;
            m_bid[m] = 0;
            m_next_bid[m] = 0;
         end
      end else begin
         ne = (occ > 0);
         h  = ne ? grant_q[0] : 0;
         er = '0;
         if (ne) er[h] = w_ready_i;
         chk("outstanding", 64'(outstanding_o), 64'(occ));
         chk("beat_cnt", 64'(beat_cnt_o), 64'(mbeat));
         chk("onehot_err", 64'(onehot_err_o), 64'(merr));
         chk("aw_gnt", 64'(aw_gnt_o), 64'(aw_gnt_i && occ != D));
         chk("w_ready", 64'(w_ready_o), 64'(er));
         chk("w_valid", 64'(w_valid_o), 64'(ne ? w_valid_i[h] : 1'b0));
         chk("w_last", 64'(w_last_o), 64'(ne ? w_last_i[h] : 1'b0));
         chk("w_data", w_data_o, ne ? w_data_i[h*WW +: WW] : 64'd0);
         fire_s = w_valid_i & w_ready_o;
         push = aw_req_i && aw_gnt_i && occ != D;
         bt   = ne && w_valid_i[h] && w_ready_i;
         pop  = bt && w_last_i[h];
         if (pop) begin
            void'(grant_q.pop_front());
            mbeat = 0;
         end else if (bt && mbeat < 255) begin
            mbeat++;
         end
         if (push) begin
            pm = 0;
            for (int m = NM - 1; m >= 0; m--) if (aw_master_gnt_i[m]) pm = m;
            if (!$onehot(aw_master_gnt_i)) merr = 1;
            grant_q.push_back(pm);
            len = (force_len != 0) ? force_len : int'($urandom_range(1, 4));
            force_len = 0;
            dir_vec = '0;
            m_len[pm].push_back(len);
            for (int b = 0; b < len; b++)
               exp_q.push_back({b == len - 1, mk(pm, m_next_bid[pm], b)});
            m_next_bid[pm]++;
         end
         occ = occ + int'(push) - int'(pop);
      end
   end

   always @(negedge clk) begin : monitor
      logic [64:0] e;
      if (rst_n && w_valid_o && w_ready_i) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_underflow: beat %h accepted with no burst expected at %0t",
                     w_data_o, $time);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", w_data_o, e[63:0]);
            chk("sb_last", 64'(w_last_o), 64'(e[64]));
         end
      end
   end

   task automatic drive();
      for (int m = 0; m < NM; m++) begin
         if (fire_s[m] && m_len[m].size() > 0) begin
            m_beat[m]++;
            if (m_beat[m] == m_len[m][0]) begin
               void'(m_len[m].pop_front());
               m_beat[m] = 0;
               m_bid[m]++;
            end
         end
      end
      fire_s = '0;
      if (dir_vec != '0) begin
         aw_req_i = 1'b1;
         aw_gnt_i = 1'b1;
         aw_master_gnt_i = dir_vec;
      end else begin
         aw_req_i = ($urandom % 100) < req_pct;
         aw_gnt_i = ($urandom % 100) < gnt_pct;
         aw_master_gnt_i = NM'(1) << $urandom_range(0, NM - 1);
      end
      w_ready_i = ($urandom % 100) < rdy_pct;
      for (int m = 0; m < NM; m++) begin
         if (m_len[m].size() > 0) begin
            w_valid_i[m] = ($urandom % 100) < val_pct;
            w_data_i[m*WW +: WW] = mk(m, m_bid[m], m_beat[m]);
            w_last_i[m] = (m_beat[m] == m_len[m][0] - 1);
         end else begin
            w_valid_i[m] = stale[m];
            w_data_i[m*WW +: WW] = {$urandom, $urandom};
            w_last_i[m] = 1'($urandom);
         end
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
      chk({tag, "_beat_cnt"}, 64'(beat_cnt_o), 64'd0);
      chk({tag, "_onehot_err"}, 64'(onehot_err_o), 64'd0);
      chk({tag, "_w_valid"}, 64'(w_valid_o), 64'd0);
      chk({tag, "_w_last"}, 64'(w_last_o), 64'd0);
      chk({tag, "_w_ready"}, 64'(w_ready_o), 64'd0);
      chk({tag, "_w_data"}, w_data_o, 64'd0);
      chk({tag, "_aw_gnt"}, 64'(aw_gnt_o), 64'(aw_gnt_i));
   endtask

   task automatic wait_occ_below(input int lim, input int budget, input string tag);
      for (int i = 0; i < budget && occ >= lim; i++) cyc(1);
      chk(tag, 64'(occ < lim), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      aw_req_i = 1'b0;
      aw_gnt_i = 1'b1;
      aw_master_gnt_i = '0;
      w_valid_i = '0;
      w_data_i = '0;
      w_last_i = '0;
      w_ready_i = 1'b1;
      req_pct = 0; gnt_pct = 80; rdy_pct = 70; val_pct = 80;
      dir_vec = '0; force_len = 0; stale = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      rst_n = 1'b1;

      // mixed traffic, then a starved slave to fill the FIFO, then heavy overlap
      req_pct = 60;
      cyc(800);
      rdy_pct = 0;
      cyc(60);
      rdy_pct = 90;
      cyc(400);
      req_pct = 100; rdy_pct = 50; val_pct = 100;
      cyc(300);

      // non-one-hot grant 5'b00110 must encode as master 1 and latch the error
      req_pct = 0; rdy_pct = 100;
      wait_occ_below(D, 200, "wait_not_full");
      dir_vec = 5'b00110;
      for (int i = 0; i < 50 && dir_vec != '0; i++) cyc(1);
      chk("onehot_push_done", 64'(dir_vec), 64'd0);
      cyc(1);
      chk("onehot_err_set", 64'(onehot_err_o), 64'd1);
      chk("onehot_tail_idx", 64'(grant_q[grant_q.size()-1]), 64'd1);
      req_pct = 60; rdy_pct = 70; val_pct = 80;
      cyc(300);

      // reset in the middle of a burst
      req_pct = 100; rdy_pct = 100; val_pct = 100;
      for (int i = 0; i < 500 && mbeat < 2; i++) cyc(1);
      chk("mid_burst_reached", 64'(mbeat >= 2), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      req_pct = 0;
      stale = '1;
      cyc(2);
      rst_n = 1'b1;
      cyc(10);
      stale = '0;
      req_pct = 60; rdy_pct = 70; val_pct = 80;
      cyc(300);

      // long burst drives beat_cnt into saturation
      req_pct = 0; rdy_pct = 100; val_pct = 100;
      wait_occ_below(1, 500, "drain_before_long");
      force_len = 258;
      dir_vec = 5'b00010;
      cyc(280);

      req_pct = 0; rdy_pct = 100; val_pct = 100;
      wait_occ_below(1, 2000, "final_drain");
      cyc(2);
      chk("final_outstanding", 64'(outstanding_o), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
